// File: rtl/button_event_arbiter_pkg.sv
// Shared types and defaults for the button event arbiter.
//   edge_state_t  : per-channel debounce FSM encoding
//   DIV_W_DEFAULT : default sample tick divider width (tick every 2^DIV_W clk)
package button_evt_pkg;

  typedef enum logic [1:0] {
    ZERO   = 2'd0,
    CHANGE = 2'd1,
    ONE    = 2'd2
  } edge_state_t;

  localparam int unsigned DIV_W_DEFAULT = 8;

endpackage

// File: rtl/button_event_arbiter_edge_channel.sv
// One button channel: 2-flop synchronizer, ZERO/CHANGE/ONE debounce FSM
// advanced on sample_tick, and the pending / sticky overflow flags.
// Ports:
//   clk, rst_n   : system clock, async active-low reset
//   btn          : raw asynchronous button level
//   sample_tick  : clock enable for the FSM
//   grant        : arbiter is taking this channel's pending event this cycle
//   ovf_clr      : clears the overflow flag
//   pending      : debounced rising edge latched, not yet granted
//   overflow     : an event arrived while already pending
module edge_channel
  import button_evt_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  input  logic sample_tick,
  input  logic grant,
  input  logic ovf_clr,
  output logic pending,
  output logic overflow
);

  logic        sync1, sync2;
  edge_state_t state, state_nxt;
  logic        fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ZERO;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (sample_tick) begin
      case (state)
        ZERO:    state_nxt = sync2 ? CHANGE : ZERO;
        CHANGE:  state_nxt = sync2 ? ONE    : ZERO;
        ONE:     state_nxt = sync2 ? ONE    : ZERO;
        default: state_nxt = ZERO;
      endcase
    end
  end

  always_comb begin
    fire = sample_tick && (state == CHANGE) && sync2;
  end

  // A new event beats a same-cycle grant: the request stays pending and
  // is not counted as an overflow, since the old one is being consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (fire)       pending <= 1'b1;
      else if (grant) pending <= 1'b0;

      if (fire && pending && !grant) overflow <= 1'b1;
      else if (ovf_clr)              overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/button_event_arbiter.sv
// Debounced push-button event arbiter.
// Per-channel debounce/pending logic lives in edge_channel; this level holds
// the sample tick divider, the round-robin arbiter and the event register.
// Ports:
//   clk, rst_n           : system clock, async active-low reset
//   btn_in[N_REQ]        : raw button levels
//   evt_ready            : consumer accepts the presented event
//   ovf_clr              : one-cycle pulse clearing all overflow bits
//   evt_valid, evt_id    : registered event port
//   pending[N_REQ]       : per-channel latched, not-yet-granted events
//   overflow[N_REQ]      : sticky per-channel overflow flags
module button_event_arbiter
  import button_evt_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DIV_W = DIV_W_DEFAULT,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] btn_in,
  input  logic             evt_ready,
  input  logic             ovf_clr,
  output logic             evt_valid,
  output logic [ID_W-1:0]  evt_id,
  output logic [N_REQ-1:0] pending,
  output logic [N_REQ-1:0] overflow
);

  logic [DIV_W-1:0] tick_cnt;
  logic             sample_tick;
  logic [ID_W-1:0]  last_grant;
  logic [ID_W-1:0]  winner;
  logic             found;
  logic             slot_free;
  logic [N_REQ-1:0] grant;
  int unsigned      idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_cnt <= '0;
    else        tick_cnt <= tick_cnt + 1'b1;
  end

  always_comb begin
    sample_tick = &tick_cnt;
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_ch
    edge_channel u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn         (btn_in[g]),
      .sample_tick (sample_tick),
      .grant       (grant[g]),
      .ovf_clr     (ovf_clr),
      .pending     (pending[g]),
      .overflow    (overflow[g])
    );
  end

  always_comb begin
    slot_free = !evt_valid || evt_ready;
  end

  // Search starts one past the last winner and wraps, so the most recently
  // served channel is considered last.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && pending[idx[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    grant = '0;
    if (slot_free && found) grant[winner] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid  <= 1'b0;
      evt_id     <= '0;
      last_grant <= ID_W'(N_REQ - 1);
    end else if (slot_free) begin
      if (found) begin
        evt_valid  <= 1'b1;
        evt_id     <= winner;
        last_grant <= winner;
      end else begin
        evt_valid  <= 1'b0;
      end
    end
  end

endmodule
